// File: rtl/weight_fetch_streamer_pkg.sv
// Shared types for the weight fetch path.
// Buffer geometry, fetch FSM states and the command bundle.
package weight_pkg;

  localparam int WB_ADDR_W = 15;
  localparam int WB_DATA_W = 64;
  localparam int WB_DEPTH  = 32768;
  localparam int WB_LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FINISH
  } fetch_state_t;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] base_addr;
    logic [WB_LEN_W-1:0]  length;
  } fetch_cmd_t;

endpackage

// File: rtl/weight_fetch_streamer_if.sv
// Command, weight-buffer read port and weight stream bundle.
// master is the streamer side, slave is its environment.
interface weight_fetch_streamer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base_addr;
  logic [LEN_W-1:0]  cmd_length;
  logic              abort;
  logic              mem_enable;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_read_data;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic              w_last;
  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, cmd_base_addr, cmd_length, abort,
    input  mem_read_data, w_ready,
    output cmd_ready, mem_enable, mem_write_en, mem_addr,
    output w_valid, w_data, w_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_base_addr, cmd_length, abort,
    output mem_read_data, w_ready,
    input  cmd_ready, mem_enable, mem_write_en, mem_addr,
    input  w_valid, w_data, w_last, busy, done
  );

endinterface

// File: rtl/weight_fetch_streamer_fifo.sv
// Skid FIFO between the weight buffer read port and the MAC stream.
// Flush wins over a same-cycle push or pop.
module weight_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/weight_fetch_streamer.sv
// Streams a (base, length) range of 64-bit weights from the buffer
// to the MAC array, issuing reads only when the skid FIFO has room.
module weight_fetch_streamer
  import weight_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 64,
  parameter int LEN_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  weight_fetch_streamer_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  generate
    if (FIFO_DEPTH < 3) begin : g_depth_chk
      $error("FIFO_DEPTH must be >= 3 for full throughput");
    end
  endgenerate

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  fetch_cmd_t        cmd;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  beats_q;
  logic              inflight_q;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occ;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic              active;
  logic              abort_act;
  logic              can_issue;
  logic              issue;
  logic              pop;

  assign cmd = '{
    base_addr: WB_ADDR_W'(bus.cmd_base_addr),
    length:    WB_LEN_W'(bus.cmd_length)
  };

  assign active    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign abort_act = bus.abort && active;
  // Reads in flight count against the FIFO so returning data always fits.
  assign occ       = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign can_issue = (occ < (CW+1)'(FIFO_DEPTH)) && !fifo_full;
  assign issue     = (state_q == ST_FETCH) && can_issue && !bus.abort;
  assign pop       = !fifo_empty && bus.w_ready;

  weight_stream_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(abort_act),
    .push (inflight_q),
    .wdata(bus.mem_read_data),
    .pop  (pop),
    .rdata(fifo_head),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid)
          state_d = (cmd.length == '0) ? ST_FINISH : ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.abort)
          state_d = ST_IDLE;
        else if (issue && rem_q == LEN_W'(1))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.abort)
          state_d = ST_IDLE;
        else if (pop && beats_q == LEN_W'(1))
          state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready    = (state_q == ST_IDLE);
    bus.busy         = (state_q != ST_IDLE);
    bus.done         = (state_q == ST_FINISH);
    bus.mem_enable   = issue;
    bus.mem_write_en = 1'b0;
    bus.mem_addr     = addr_q;
    bus.w_valid      = !fifo_empty;
    bus.w_data       = fifo_head;
    bus.w_last       = !fifo_empty && (beats_q == LEN_W'(1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (state_q == ST_IDLE && bus.cmd_valid) begin
        addr_q  <= ADDR_W'(cmd.base_addr);
        rem_q   <= LEN_W'(cmd.length);
        beats_q <= LEN_W'(cmd.length);
      end else if (abort_act) begin
        rem_q   <= '0;
        beats_q <= '0;
      end else begin
        if (issue) begin
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
        end
        if (pop) beats_q <= beats_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_weight_fetch_streamer.sv
// Directed bench for weight_fetch_streamer with a mem[i]=i buffer model.
module tb_weight_fetch_streamer;
  import weight_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic clock = 1'b0;
  logic reset;

  weight_fetch_streamer_if #(
    .ADDR_W(15), .DATA_W(64), .LEN_W(16)
  ) bus ();

  weight_fetch_streamer #(
    .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(15), .DATA_W(64), .LEN_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (bus.mem_enable) bus.mem_read_data <= 64'(bus.mem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] got_data[$];
  logic        got_last[$];
  logic [14:0] iss_addr[$];
  int   t_first_valid, t_done, n_done, viol, unstable;
  logic timeout, accept_ready, ready_after;
  logic abort_memen, post_valid, post_busy;

  // Drives one command and records everything observed, one sample per cycle.
  task automatic stream(input logic [14:0] base, input int len,
                        input bit stall, input int abort_at,
                        input int max_cyc);
    int c = 0;
    int issued = 0;
    int popped = 0;
    bit prev_stall = 0;
    logic [63:0] prev_data = '0;
    bit fin = 0;
    bit ab = 0;
    got_data.delete(); got_last.delete(); iss_addr.delete();
    t_first_valid = -1; t_done = -1; n_done = 0; viol = 0; unstable = 0;
    abort_memen = 1; post_valid = 1; post_busy = 1; accept_ready = 0;
    bus.cmd_base_addr = base;
    bus.cmd_length = 16'(len);
    bus.cmd_valid = 1;
    while (!fin && c < max_cyc) begin
      bus.w_ready = stall ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      bus.abort = 0;
      if (abort_at >= 0 && !ab && popped == abort_at) begin
        bus.abort = 1;
        bus.w_ready = 0;
      end
      #1;
      if (c == 0) accept_ready = bus.cmd_ready;
      if (bus.mem_enable) begin
        if (issued - popped >= FIFO_DEPTH) viol++;
        iss_addr.push_back(bus.mem_addr);
        issued++;
      end
      if (prev_stall && (!bus.w_valid || bus.w_data !== prev_data))
        unstable++;
      if (bus.w_valid && t_first_valid < 0) t_first_valid = c;
      if (bus.w_valid && bus.w_ready) begin
        got_data.push_back(bus.w_data);
        got_last.push_back(bus.w_last);
        popped++;
      end
      prev_stall = bus.w_valid && !bus.w_ready;
      prev_data = bus.w_data;
      if (bus.done) begin
        n_done++;
        t_done = c;
        fin = 1;
      end
      if (bus.abort) begin
        abort_memen = bus.mem_enable;
        ab = 1;
      end else if (ab) begin
        post_valid = bus.w_valid;
        post_busy = bus.busy;
        fin = 1;
      end
      @(posedge clock);
      #1;
      bus.cmd_valid = 0;
      c++;
    end
    bus.abort = 0;
    bus.w_ready = 1;
    timeout = !fin;
    #1;
    ready_after = bus.cmd_ready;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.cmd_ready, bus.mem_enable, bus.w_valid, bus.w_last,
         bus.busy, bus.done, bus.mem_write_en} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 1000000",
        {bus.cmd_ready, bus.mem_enable, bus.w_valid, bus.w_last,
         bus.busy, bus.done, bus.mem_write_en});
    end
    n_cmp++;
    if (bus.mem_addr !== 15'h0) begin
      n_bad++;
      $display("FAIL reset_addr: got %h want 0000", bus.mem_addr);
    end
  endtask

  task automatic test_basic();
    stream(15'h0010, 4, 0, -1, 40);
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_bad++; $display("FAIL basic_timeout: got %b want 0", timeout);
    end
    n_cmp++;
    if (accept_ready !== 1'b1) begin
      n_bad++; $display("FAIL basic_cmd_ready: got %b want 1", accept_ready);
    end
    n_cmp++;
    if (t_first_valid != 3) begin
      n_bad++; $display("FAIL basic_latency: got %0d want 3", t_first_valid);
    end
    n_cmp++;
    if (got_data.size() != 4) begin
      n_bad++; $display("FAIL basic_count: got %0d want 4", got_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got_data.size() || got_data[i] !== 64'(16 + i) ||
          got_last[i] !== (i == 3)) begin
        n_bad++;
        $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i,
          (i < got_data.size()) ? got_data[i] : 64'hx,
          (i < got_last.size()) ? got_last[i] : 1'bx, 64'(16 + i), i == 3);
      end
      n_cmp++;
      if (i >= iss_addr.size() || iss_addr[i] !== 15'(16 + i)) begin
        n_bad++;
        $display("FAIL basic_addr%0d: got %h want %h", i,
          (i < iss_addr.size()) ? iss_addr[i] : 15'hx, 15'(16 + i));
      end
    end
    n_cmp++;
    if (t_done != 7) begin
      n_bad++; $display("FAIL basic_done_cycle: got %0d want 7", t_done);
    end
    n_cmp++;
    if (ready_after !== 1'b1) begin
      n_bad++; $display("FAIL basic_ready_after: got %b want 1", ready_after);
    end
  endtask

  task automatic test_wrap();
    logic [14:0] a;
    stream(15'h7FFE, 4, 0, -1, 40);
    n_cmp++;
    if (n_done != 1 || got_data.size() != 4 || iss_addr.size() != 4) begin
      n_bad++;
      $display("FAIL wrap_counts: got done=%0d beats=%0d reads=%0d want 1/4/4",
        n_done, got_data.size(), iss_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      a = 15'h7FFE + 15'(i);
      n_cmp++;
      if (i >= iss_addr.size() || iss_addr[i] !== a ||
          i >= got_data.size() || got_data[i] !== 64'(a)) begin
        n_bad++;
        $display("FAIL wrap_%0d: got addr=%h data=%h want %h", i,
          (i < iss_addr.size()) ? iss_addr[i] : 15'hx,
          (i < got_data.size()) ? got_data[i] : 64'hx, a);
      end
    end
  endtask

  task automatic test_stall();
    stream(15'h0040, 8, 1, -1, 100);
    n_cmp++;
    if (timeout !== 1'b0 || n_done != 1 || got_data.size() != 8) begin
      n_bad++;
      $display("FAIL stall_counts: got to=%b done=%0d beats=%0d want 0/1/8",
        timeout, n_done, got_data.size());
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= got_data.size() || got_data[i] !== 64'(64 + i) ||
          got_last[i] !== (i == 7)) begin
        n_bad++;
        $display("FAIL stall_beat%0d: got %h want %h", i,
          (i < got_data.size()) ? got_data[i] : 64'hx, 64'(64 + i));
      end
    end
    n_cmp++;
    if (unstable != 0) begin
      n_bad++; $display("FAIL stall_hold: got %0d changes want 0", unstable);
    end
    n_cmp++;
    if (viol != 0) begin
      n_bad++; $display("FAIL stall_credit: got %0d overissues want 0", viol);
    end
  endtask

  task automatic test_zero_len();
    stream(15'h0100, 0, 0, -1, 10);
    n_cmp++;
    if (t_done != 1 || n_done != 1) begin
      n_bad++; $display("FAIL zero_done: got cycle %0d want 1", t_done);
    end
    n_cmp++;
    if (iss_addr.size() != 0 || t_first_valid != -1) begin
      n_bad++;
      $display("FAIL zero_activity: got reads=%0d first_valid=%0d want 0/-1",
        iss_addr.size(), t_first_valid);
    end
    n_cmp++;
    if (ready_after !== 1'b1) begin
      n_bad++; $display("FAIL zero_ready_after: got %b want 1", ready_after);
    end
  endtask

  task automatic test_abort();
    int late_done = 0;
    stream(15'h0300, 100, 0, 5, 200);
    n_cmp++;
    if (abort_memen !== 1'b0) begin
      n_bad++; $display("FAIL abort_mem_en: got %b want 0", abort_memen);
    end
    n_cmp++;
    if (post_valid !== 1'b0 || post_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: got valid=%b busy=%b want 0/0",
        post_valid, post_busy);
    end
    n_cmp++;
    if (n_done != 0 || got_data.size() != 5) begin
      n_bad++;
      $display("FAIL abort_counts: got done=%0d beats=%0d want 0/5",
        n_done, got_data.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= got_data.size() || got_data[i] !== 64'(768 + i) ||
          got_last[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_beat%0d: got %h want %h", i,
          (i < got_data.size()) ? got_data[i] : 64'hx, 64'(768 + i));
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.done || bus.mem_enable || bus.w_valid) late_done++;
      @(posedge clock);
      #1;
    end
    n_cmp++;
    if (late_done != 0) begin
      n_bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", late_done);
    end
    stream(15'h0200, 2, 0, -1, 40);
    n_cmp++;
    if (n_done != 1 || got_data.size() != 2 ||
        got_data[0] !== 64'h200 || got_data[1] !== 64'h201 ||
        got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_next_cmd: got %0d beats done=%0d want 200,201",
        got_data.size(), n_done);
    end
  endtask

  task automatic test_async_reset();
    bus.w_ready = 0;
    bus.cmd_base_addr = 15'h0050;
    bus.cmd_length = 16'd20;
    bus.cmd_valid = 1;
    @(posedge clock);
    #1;
    bus.cmd_valid = 0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.w_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_pre: got busy=%b valid=%b want 1/1",
        bus.busy, bus.w_valid);
    end
    #2;
    reset = 1;
    #1;
    test_reset();
    #2;
    reset = 0;
    @(posedge clock);
    #1;
    stream(15'h0123, 3, 0, -1, 40);
    n_cmp++;
    if (n_done != 1 || got_data.size() != 3 || got_data[0] !== 64'h123 ||
        got_data[1] !== 64'h124 || got_data[2] !== 64'h125 ||
        got_last[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_next_cmd: got %0d beats done=%0d want 123..125",
        got_data.size(), n_done);
    end
  endtask

  initial begin
    bus.cmd_valid = 0;
    bus.cmd_base_addr = '0;
    bus.cmd_length = '0;
    bus.abort = 0;
    bus.w_ready = 1;
    reset = 1;
    #3;
    test_reset();
    @(posedge clock);
    #1;
    reset = 0;
    @(posedge clock);
    #1;
    test_basic();
    test_wrap();
    test_stall();
    test_zero_len();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/weight_fetch_streamer.md
Name: weight_fetch_streamer

Overview:
Read-side stage that sits directly downstream of the 256KB weight buffer and drives one of its ports in read-only mode. It accepts a (base address, length) fetch command and streams 64-bit weight words to the MAC array over a valid/ready interface. Backpressure is handled with an internal skid FIFO and a read-credit check. It is the only path from stored weights into compute.

Parameters:
FIFO_DEPTH, 4, skid FIFO entries; must be >= 3 for 1 beat/cycle throughput (elaboration assertion)
ADDR_W, 15, weight buffer address width (32K entries)
DATA_W, 64, weight word width
LEN_W, 16, command length width (0..32768 words)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  fetch command valid
cmd_ready  out  1  block idle and able to accept a command
cmd_base_addr  in  ADDR_W  first word address
cmd_length  in  LEN_W  number of words to fetch
abort  in  1  cancel the active fetch
mem_enable  out  1  weight buffer port enable
mem_write_en  out  1  constant 0 (read-only)
mem_addr  out  ADDR_W  weight buffer address
mem_read_data  in  DATA_W  registered read data; valid the cycle after mem_enable
w_valid  out  1  weight beat valid
w_ready  in  1  MAC array ready
w_data  out  DATA_W  weight word
w_last  out  1  final beat of the command
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous and active-high; no clock edge is needed for reset to take effect.
- Reset values: state IDLE, cmd_ready=1, mem_enable=0, mem_addr=0, w_valid=0, w_last=0, busy=0, done=0. FIFO is emptied, counters are cleared, and the in-flight flag is cleared.
- States: IDLE, FETCH, DRAIN, FINISH.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch address and length.
  - If length > 0, go to FETCH.
  - If length = 0, go to FINISH; no memory access and no beats.
- FETCH:
  - A read issues (mem_enable=1, mem_addr=current address) only when fifo_count + inflight < FIFO_DEPTH. inflight is a 1-bit register equal to last cycle's mem_enable.
  - After each issue, the address increments modulo 2^ADDR_W, so 32767 wraps to 0. The remaining count decrements.
  - After the final issue, go to DRAIN.
- Data capture: mem_read_data is pushed into the FIFO in the cycle when inflight=1. The credit rule guarantees the FIFO never overflows, so no drop logic exists.
- Output:
  - w_valid = FIFO not empty; w_data = FIFO head.
  - A beat transfers on w_valid && w_ready.
  - w_last=1 on the head entry when it is the command's final word (tracked by a beats-remaining counter).
  - w_data and w_last must hold stable while w_valid=1 and w_ready=0.
- DRAIN: when the last beat transfers, go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE. cmd_ready is 0 in FINISH.
- Latency: command accepted at edge E0 → first mem_enable in the cycle after E0 → data captured at E2 → w_valid high after E2. With w_ready held at 1, one beat per cycle thereafter.
- Abort (sampled in FETCH/DRAIN):
  - mem_enable is forced to 0 in that same cycle.
  - At the next edge: FIFO flushed, in-flight read discarded, state goes to IDLE, no done pulse, no w_last.
  - Abort in IDLE or FINISH is ignored.
- Simultaneous FIFO push and pop in one cycle: count is unchanged and ordering is preserved. A pop on an empty FIFO cannot occur because w_valid gates it.
- Maximum length 32768 fetches the entire buffer exactly once, including the wrap.

Decomposition:
- Shared package weight_pkg:
  - WB_ADDR_W=15, WB_DATA_W=64, WB_DEPTH=32768
  - fetch-state enum typedef
  - fetch-command struct typedef (base_addr, length)
- One sub-module: weight_stream_fifo, a synchronous FIFO with async reset, DEPTH/WIDTH parameters, push/pop/count/empty/full, and a flush input.
- All credit, address, and FSM logic lives in weight_fetch_streamer.

Test Plan:
- Command base=0x0010, length=4, w_ready=1, with memory preloaded mem[i]=i → w_data 0x10,0x11,0x12,0x13 on consecutive cycles; w_last on 0x13; done one cycle after the last beat; first w_valid 3 cycles after acceptance.
- Command base=0x7FFE, length=4 → addresses 0x7FFE,0x7FFF,0x0000,0x0001 issued; data returned in that order.
- Command length=8, w_ready toggled 1,0,0,1 repeating → all 8 words delivered in order with no loss or duplication; data held stable while stalled; mem_enable never issues when fifo_count+inflight=FIFO_DEPTH.
- Command length=0 → no mem_enable, no w_valid; done pulses in the cycle after acceptance; cmd_ready=1 again the cycle after that.
- Command length=100, abort pulsed after 5 beats → mem_enable low in the abort cycle; w_valid=0 and state IDLE the next cycle; no done; a following command base=0x0200, length=2 streams correctly.
- Reset asserted asynchronously mid-FETCH, between clock edges → all outputs immediately at reset values; after release the next command streams correctly.
